// File: rtl/relock_supervisor.sv
// relock_supervisor: lock supervision FSM sequencing one PID channel's relock sweep and loop filter
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   enable_i                 supervisor enable (low forces OFF)
//   min_val_i, max_val_i     lock window bounds (exclusive, unsigned)
//   signal_i                 monitored signal
//   railed_i                 PID rail flags {upper, lower}
//   debounce_i, settle_i     loss debounce and lock settle limits (cycles)
//   timeout_i                per-attempt sweep timeout (0 = none)
//   max_attempts_i           attempt limit (0 = unlimited)
//   ack_i                    fault acknowledge
//   relock_on_o, pid_hold_o, pid_clear_o   sweep / PID control
//   locked_o, fault_o, state_o             status
//   attempts_o, relocks_o                  attempt and relock counters
module relock_supervisor #(
    parameter int CNT_BITS = 24,
    parameter int ATT_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic [11:0]         min_val_i,
    input  logic [11:0]         max_val_i,
    input  logic [11:0]         signal_i,
    input  logic [1:0]          railed_i,
    input  logic [CNT_BITS-1:0] debounce_i,
    input  logic [CNT_BITS-1:0] settle_i,
    input  logic [CNT_BITS-1:0] timeout_i,
    input  logic [ATT_BITS-1:0] max_attempts_i,
    input  logic                ack_i,
    output logic                relock_on_o,
    output logic                pid_hold_o,
    output logic                pid_clear_o,
    output logic                locked_o,
    output logic                fault_o,
    output logic [2:0]          state_o,
    output logic [ATT_BITS-1:0] attempts_o,
    output logic [15:0]         relocks_o
);
    typedef enum logic [2:0] {
        OFF    = 3'd0,
        LOCKED = 3'd1,
        LOST   = 3'd2,
        CLEAR  = 3'd3,
        SWEEP  = 3'd4,
        SETTLE = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t              state, nxt;
    logic                in_win_r;
    logic                begin_att;
    logic                restart;
    logic [CNT_BITS-1:0] timer;
    logic [ATT_BITS-1:0] att_nxt;
    logic [15:0]         rel_nxt;

    assign state_o = state;

    always_comb begin
        nxt       = state;
        att_nxt   = attempts_o;
        rel_nxt   = relocks_o;
        begin_att = 1'b0;
        case (state)
            OFF:    if (enable_i) nxt = SETTLE;
            LOCKED: if (!in_win_r) nxt = LOST;
            LOST:   if (in_win_r) nxt = LOCKED;
                    else if (timer >= debounce_i) begin_att = 1'b1;
            CLEAR:  nxt = SWEEP;
            SWEEP:  if (in_win_r) nxt = SETTLE;
                    else if (timeout_i != '0 && timer >= timeout_i) begin_att = 1'b1;
            SETTLE: if (!in_win_r) nxt = SWEEP;
                    else if (timer >= settle_i) begin
                        nxt     = LOCKED;
                        att_nxt = '0;
                        if (attempts_o != '0 && relocks_o != 16'hFFFF) rel_nxt = relocks_o + 16'd1;
                    end
            FAULT:  if (ack_i) begin
                        nxt     = SETTLE;
                        att_nxt = '0;
                    end
            default: nxt = OFF;
        endcase
        if (begin_att) begin
            if (max_attempts_i != '0 && attempts_o == max_attempts_i) nxt = FAULT;
            else begin
                if (attempts_o != '1) att_nxt = attempts_o + 1'b1;
                nxt = (railed_i != 2'b00) ? CLEAR : SWEEP;
            end
        end
        if (!enable_i) begin
            nxt     = OFF;
            att_nxt = '0;
        end
        // a retried sweep restarts its timeout window even though the state is unchanged
        restart = begin_att || (nxt != state);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= OFF;
            in_win_r    <= 1'b0;
            timer       <= '0;
            attempts_o  <= '0;
            relocks_o   <= '0;
            relock_on_o <= 1'b0;
            pid_hold_o  <= 1'b0;
            pid_clear_o <= 1'b0;
            locked_o    <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            in_win_r    <= (min_val_i < signal_i) && (signal_i < max_val_i);
            state       <= nxt;
            timer       <= restart ? '0 : (timer == '1 ? timer : timer + 1'b1);
            attempts_o  <= att_nxt;
            relocks_o   <= rel_nxt;
            relock_on_o <= (nxt == SWEEP) || (nxt == SETTLE);
            pid_hold_o  <= (nxt == CLEAR) || (nxt == SWEEP) || (nxt == FAULT);
            pid_clear_o <= nxt == CLEAR;
            locked_o    <= nxt == LOCKED;
            fault_o     <= nxt == FAULT;
        end
    end
endmodule
